// File: rtl/mac_tcdm_req_buffer.sv
// Per-port registered request FIFO between the MAC engine TCDM masters and the interconnect,
// with an outstanding-credit limit, sticky response-protocol error flags and a synchronous flush.
module mac_tcdm_req_buffer #(
    parameter int unsigned MP      = 4,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic [MP-1:0]          in_req,
    output logic [MP-1:0]          in_gnt,
    input  logic [MP*AW-1:0]       in_add,
    input  logic [MP-1:0]          in_wen,
    input  logic [MP*(DW/8)-1:0]   in_be,
    input  logic [MP*DW-1:0]       in_data,
    output logic [MP*DW-1:0]       in_r_data,
    output logic [MP-1:0]          in_r_valid,
    output logic [MP-1:0]          tcdm_req,
    input  logic [MP-1:0]          tcdm_gnt,
    output logic [MP*AW-1:0]       tcdm_add,
    output logic [MP-1:0]          tcdm_wen,
    output logic [MP*(DW/8)-1:0]   tcdm_be,
    output logic [MP*DW-1:0]       tcdm_data,
    input  logic [MP*DW-1:0]       tcdm_r_data,
    input  logic [MP-1:0]          tcdm_r_valid,
    output logic                   busy_o,
    output logic [MP-1:0]          err_o
);

    localparam int unsigned BW   = DW / 8;
    localparam int unsigned CW_F = $clog2(DEPTH + 1);
    localparam int unsigned CW_I = $clog2(MAX_OUT + 1);
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned EW   = AW + DW + BW + 1;

    // Pointers wrap at DEPTH, so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (32'(p) == DEPTH - 1) return '0;
        return p + 1'b1;
    endfunction

    logic [MP-1:0] w_busy;

    assign in_r_data  = tcdm_r_data;
    assign in_r_valid = tcdm_r_valid & {MP{rst_ni}};
    assign busy_o     = |w_busy;

    for (genvar gi = 0; gi < MP; gi++) begin : g_port
        logic [EW-1:0]   r_mem [DEPTH];
        logic [PW-1:0]   r_wptr, r_rptr, w_wptr_d, w_rptr_d;
        logic [CW_F-1:0] r_cnt, w_cnt_d;
        logic [CW_I-1:0] r_infl, w_infl_d;
        logic            r_err, w_err_d;
        logic            w_gnt, w_req, w_push, w_pop, w_rvalid;
        logic [EW-1:0]   w_head;

        // Grant uses pre-pop state only: no same-cycle credit reuse.
        always_comb begin
            w_gnt    = rst_ni & ~clear_i & (32'(r_cnt) < DEPTH)
                       & ((32'(r_cnt) + 32'(r_infl)) < MAX_OUT);
            w_req    = (r_cnt != '0) & ~clear_i;
            w_push   = in_req[gi] & w_gnt;
            w_pop    = w_req & tcdm_gnt[gi];
            w_rvalid = tcdm_r_valid[gi];
            w_head   = r_mem[r_rptr];
        end

        always_comb begin
            w_wptr_d = r_wptr;
            w_rptr_d = r_rptr;
            w_cnt_d  = r_cnt;
            w_infl_d = r_infl;
            w_err_d  = r_err;

            if (clear_i) begin
                w_wptr_d = '0;
                w_rptr_d = '0;
                w_cnt_d  = '0;
                w_err_d  = 1'b0;
            end else begin
                if (w_push) w_wptr_d = ptr_inc(r_wptr);
                if (w_pop)  w_rptr_d = ptr_inc(r_rptr);
                case ({w_push, w_pop})
                    2'b10:   w_cnt_d = r_cnt + 1'b1;
                    2'b01:   w_cnt_d = r_cnt - 1'b1;
                    default: w_cnt_d = r_cnt;
                endcase
                if (w_rvalid && !w_pop && r_infl == '0) w_err_d = 1'b1;
            end

            // In-flight tracking survives a flush; pop is already 0 in the clear cycle.
            case ({w_pop, w_rvalid})
                2'b10:   w_infl_d = r_infl + 1'b1;
                2'b01:   if (r_infl != '0) w_infl_d = r_infl - 1'b1;
                default: w_infl_d = r_infl;
            endcase
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
                r_infl <= '0;
                r_err  <= 1'b0;
            end else begin
                r_wptr <= w_wptr_d;
                r_rptr <= w_rptr_d;
                r_cnt  <= w_cnt_d;
                r_infl <= w_infl_d;
                r_err  <= w_err_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (w_push) begin
                r_mem[r_wptr] <= {in_wen[gi], in_be[gi*BW +: BW], in_data[gi*DW +: DW],
                                  in_add[gi*AW +: AW]};
            end
        end

        assign in_gnt[gi]             = w_gnt;
        assign tcdm_req[gi]           = w_req;
        assign tcdm_add[gi*AW +: AW]  = w_head[AW-1:0];
        assign tcdm_data[gi*DW +: DW] = w_head[AW +: DW];
        assign tcdm_be[gi*BW +: BW]   = w_head[AW+DW +: BW];
        assign tcdm_wen[gi]           = w_head[EW-1];
        assign err_o[gi]              = r_err;
        assign w_busy[gi]             = (r_cnt != '0) | (r_infl != '0);
    end

endmodule

// File: tb/tb_mac_tcdm_req_buffer.sv
// Directed bench for mac_tcdm_req_buffer (MP=4, DEPTH=2, MAX_OUT=4, 32-bit add/data).
module tb_mac_tcdm_req_buffer;

    logic          clk_i, rst_ni, clear_i;
    logic [3:0]    in_req, in_gnt, in_wen, in_r_valid;
    logic [127:0]  in_add, in_data, in_r_data;
    logic [15:0]   in_be;
    logic [3:0]    tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid;
    logic [127:0]  tcdm_add, tcdm_data, tcdm_r_data;
    logic [15:0]   tcdm_be;
    logic          busy_o;
    logic [3:0]    err_o;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int acc;

    mac_tcdm_req_buffer #(
        .MP(4), .DEPTH(2), .MAX_OUT(4), .AW(32), .DW(32)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen),
        .in_be(in_be), .in_data(in_data), .in_r_data(in_r_data), .in_r_valid(in_r_valid),
        .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt), .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen),
        .tcdm_be(tcdm_be), .tcdm_data(tcdm_data), .tcdm_r_data(tcdm_r_data),
        .tcdm_r_valid(tcdm_r_valid), .busy_o(busy_o), .err_o(err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish before 100000");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the edge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle();
        in_req = '0; tcdm_gnt = '0; tcdm_r_valid = '0; clear_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0;
        in_req = '0; in_add = '0; in_wen = '0; in_be = '1; in_data = '0;
        tcdm_gnt = '0; tcdm_r_data = '0; tcdm_r_valid = 4'b0001;
        #3;
        chk("rst_tcdm_req", 64'(tcdm_req), 64'h0);
        chk("rst_in_gnt", 64'(in_gnt), 64'h0);
        chk("rst_busy", 64'(busy_o), 64'h0);
        chk("rst_err", 64'(err_o), 64'h0);
        chk("rst_r_valid_gated", 64'(in_r_valid), 64'h0);
        tcdm_r_valid = '0;
        tick();
        rst_ni = 1'b1;
        tick();
        #1 chk("idle_gnt_all", 64'(in_gnt), 64'hF);

        // Single read on port 2.
        in_req = 4'b0100; in_add[64 +: 32] = 32'h1000; in_wen = 4'b0100;
        tick();
        in_req = '0; tcdm_gnt = 4'b0100;
        #1;
        chk("rd_tcdm_req", 64'(tcdm_req), 64'h4);
        chk("rd_tcdm_add", 64'(tcdm_add[64 +: 32]), 64'h1000);
        chk("rd_tcdm_wen", 64'(tcdm_wen[2]), 64'h1);
        tick();
        tcdm_gnt = '0; tcdm_r_valid = 4'b0100; tcdm_r_data[64 +: 32] = 32'hDEADBEEF;
        #1;
        chk("rd_r_valid", 64'(in_r_valid), 64'h4);
        chk("rd_r_data", 64'(in_r_data[64 +: 32]), 64'hDEADBEEF);
        chk("rd_busy_inflight", 64'(busy_o), 64'h1);
        tick();
        tcdm_r_valid = '0;
        #1;
        chk("rd_busy_done", 64'(busy_o), 64'h0);
        chk("rd_err", 64'(err_o), 64'h0);

        // Full FIFO on port 0 with the memory stalling.
        in_req = 4'b0001; in_add[0 +: 32] = 32'hA0; in_wen = '0;
        #1 chk("full_gnt0", 64'(in_gnt[0]), 64'h1);
        tick();
        in_add[0 +: 32] = 32'hA4;
        #1 chk("full_gnt1", 64'(in_gnt[0]), 64'h1);
        tick();
        in_add[0 +: 32] = 32'hA8;
        #1;
        chk("full_gnt_low", 64'(in_gnt[0]), 64'h0);
        chk("full_head", 64'(tcdm_add[0 +: 32]), 64'hA0);
        tick();
        in_req = '0; tcdm_gnt = 4'b0001;
        #1;
        chk("full_head_stable", 64'(tcdm_add[0 +: 32]), 64'hA0);
        chk("full_req_stable", 64'(tcdm_req[0]), 64'h1);
        tick();
        #1 chk("full_drain_2nd", 64'(tcdm_add[0 +: 32]), 64'hA4);
        tick();
        tcdm_gnt = '0;
        #1 chk("full_drained", 64'(tcdm_req[0]), 64'h0);
        tcdm_r_valid = 4'b0001;
        tick();
        tick();
        tcdm_r_valid = '0;
        #1;
        chk("full_busy_done", 64'(busy_o), 64'h0);
        chk("full_err", 64'(err_o), 64'h0);

        // Credit limit on port 1: memory always grants, responses withheld.
        acc = 0;
        in_req = 4'b0010; tcdm_gnt = 4'b0010;
        for (int c = 0; c < 8; c++) begin
            #1 if (in_gnt[1]) acc++;
            tick();
        end
        chk("credit_accepts", 64'(acc), 64'd4);
        in_req = '0; tcdm_r_valid = 4'b0010;
        #1 chk("credit_gnt_blocked", 64'(in_gnt[1]), 64'h0);
        tick();
        tcdm_r_valid = '0;
        #1 chk("credit_gnt_back", 64'(in_gnt[1]), 64'h1);
        tcdm_r_valid = 4'b0010;
        tick(); tick(); tick();
        idle();
        #1;
        chk("credit_busy_done", 64'(busy_o), 64'h0);
        chk("credit_err", 64'(err_o), 64'h0);

        // Push, pop and response together on port 3 with fifo_cnt=1, infl=1.
        in_req = 4'b1000; in_add[96 +: 32] = 32'hC0;
        tick();
        in_add[96 +: 32] = 32'hC4; tcdm_gnt = 4'b1000;
        tick();
        in_add[96 +: 32] = 32'hC8; tcdm_r_valid = 4'b1000;
        #1;
        chk("sim_head", 64'(tcdm_add[96 +: 32]), 64'hC4);
        chk("sim_gnt", 64'(in_gnt[3]), 64'h1);
        tick();
        in_req = '0; tcdm_r_valid = '0;
        #1;
        chk("sim_head_next", 64'(tcdm_add[96 +: 32]), 64'hC8);
        chk("sim_err", 64'(err_o), 64'h0);
        tick();
        tcdm_gnt = '0; tcdm_r_valid = 4'b1000;
        tick(); tick();
        tcdm_r_valid = '0;
        #1;
        chk("sim_busy_done", 64'(busy_o), 64'h0);
        chk("sim_err_final", 64'(err_o), 64'h0);

        // Spurious response on port 0, then a flush clears the flag.
        tcdm_r_valid = 4'b0001;
        tick();
        tcdm_r_valid = '0;
        #1 chk("spur_err", 64'(err_o), 64'h1);
        clear_i = 1'b1;
        #1;
        chk("spur_clr_gnt", 64'(in_gnt), 64'h0);
        tick();
        clear_i = 1'b0;
        #1 chk("spur_err_clr", 64'(err_o), 64'h0);

        // Flush with two queued and one in flight on port 0.
        in_req = 4'b0001; in_add[0 +: 32] = 32'hB0;
        tick();
        in_add[0 +: 32] = 32'hB4; tcdm_gnt = 4'b0001;
        tick();
        in_add[0 +: 32] = 32'hB8; tcdm_gnt = '0;
        tick();
        in_req = '0; clear_i = 1'b1; tcdm_gnt = 4'b0001;
        #1;
        chk("fl_req_low", 64'(tcdm_req), 64'h0);
        chk("fl_gnt_low", 64'(in_gnt), 64'h0);
        tick();
        clear_i = 1'b0; tcdm_gnt = '0;
        #1;
        chk("fl_empty", 64'(tcdm_req), 64'h0);
        chk("fl_busy_held", 64'(busy_o), 64'h1);
        tick();
        tcdm_r_valid = 4'b0001;
        #1 chk("fl_r_valid", 64'(in_r_valid), 64'h1);
        tick();
        tcdm_r_valid = '0;
        #1;
        chk("fl_busy_done", 64'(busy_o), 64'h0);
        chk("fl_err", 64'(err_o), 64'h0);

        // Reset mid-transfer drops state; a late response then flags an error.
        in_req = 4'b0010; in_add[32 +: 32] = 32'hE0;
        tick();
        in_req = '0;
        #1 chk("mr_req", 64'(tcdm_req), 64'h2);
        rst_ni = 1'b0;
        #1;
        chk("mr_req_dropped", 64'(tcdm_req), 64'h0);
        chk("mr_busy", 64'(busy_o), 64'h0);
        tick();
        rst_ni = 1'b1;
        tcdm_r_valid = 4'b0010;
        #1 chk("mr_r_valid", 64'(in_r_valid), 64'h2);
        tick();
        tcdm_r_valid = '0;
        #1 chk("mr_err", 64'(err_o), 64'h2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
